// File: rtl/hp1349a_bus_rx_if.sv
// HP1349A display-bus handshake plus the downstream FIFO write port.
// The master modport is the sending host and FIFO side; the slave modport is the receiver.
`timescale 1ns/1ps
interface hp1349a_bus_rx_if #(
  parameter int DATA_W = 15
);
  logic [DATA_W-1:0] DATA;
  logic              LDAV;
  logic              LRFD;
  logic              fifo_full;
  logic              fifo_write_en;
  logic [DATA_W:0]   fifo_write_data;

  modport master (
    output DATA, LDAV, fifo_full,
    input  LRFD, fifo_write_en, fifo_write_data
  );

  modport slave (
    input  DATA, LDAV, fifo_full,
    output LRFD, fifo_write_en, fifo_write_data
  );
endinterface

// File: rtl/hp1349a_bus_rx.sv
// HP1349A bus receiver: LDAV/LRFD handshake with settle, release-timeout and hold phases.
// Each captured word is pushed to a FIFO, with an optional drop when the FIFO stays full.
`timescale 1ns/1ps
module hp1349a_bus_rx #(
  parameter int DATA_W       = 15,
  parameter int TMR_W        = 8,
  parameter int SETTLE_CYC   = 255,
  parameter int HOLD_CYC     = 255,
  parameter int LDAV_TO      = 255,
  parameter bit DROP_ON_FULL = 1'b0,
  parameter int FULL_TO      = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  hp1349a_bus_rx_if.slave bus,
  output logic            busy,
  output logic [15:0]     word_cnt,
  output logic [7:0]      to_cnt,
  output logic [7:0]      drop_cnt,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETTLE   = 3'd1,
    S_WAIT_REL = 3'd2,
    S_HOLD     = 3'd3,
    S_CAPTURE  = 3'd4,
    S_PUSH     = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [TMR_W-1:0] L_SETTLE  = TMR_W'(SETTLE_CYC);
  localparam logic [TMR_W-1:0] L_HOLD    = TMR_W'(HOLD_CYC);
  localparam logic [TMR_W-1:0] L_LDAV_TO = TMR_W'(LDAV_TO);
  localparam logic [TMR_W-1:0] L_FULL_TO = TMR_W'(FULL_TO);
  localparam logic [TMR_W-1:0] L_ONE     = TMR_W'(1);

  state_t            r_state;
  logic              r_ldav_m, r_ldav_s;
  logic              r_armed;
  logic              r_ack;
  logic              r_to_flag;
  logic              r_we;
  logic [DATA_W:0]   r_wdata;
  logic [TMR_W-1:0]  r_timer;
  logic [15:0]       r_word_cnt;
  logic [7:0]        r_to_cnt;
  logic [7:0]        r_drop_cnt;
  logic              w_timer_zero;

  assign w_timer_zero = (r_timer == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ldav_m   <= 1'b0;
      r_ldav_s   <= 1'b0;
      r_armed    <= 1'b0;
      r_ack      <= 1'b0;
      r_to_flag  <= 1'b0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_timer    <= '0;
      r_word_cnt <= '0;
      r_to_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_ldav_m <= bus.LDAV;
      r_ldav_s <= r_ldav_m;
      // NOTE: default-low here makes the write strobe a single-cycle pulse without a separate clear path.
      r_we     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_ldav_s) begin
            r_armed <= 1'b1;
          end else if (en && r_armed) begin
            r_ack   <= 1'b1;
            r_timer <= L_SETTLE;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (w_timer_zero) begin
            r_timer <= L_LDAV_TO;
            r_state <= S_WAIT_REL;
          end else begin
            r_timer <= r_timer - L_ONE;
          end
        end
        S_WAIT_REL: begin
          if (!r_ldav_s) begin
            r_timer   <= L_HOLD;
            r_to_flag <= 1'b0;
            r_state   <= S_HOLD;
          end else if (w_timer_zero) begin
            r_timer   <= L_HOLD;
            r_to_flag <= 1'b1;
            r_to_cnt  <= (r_to_cnt == 8'hFF) ? r_to_cnt : r_to_cnt + 8'd1;
            r_state   <= S_HOLD;
          end else begin
            r_timer <= r_timer - L_ONE;
          end
        end
        S_HOLD: begin
          if (w_timer_zero) r_state <= S_CAPTURE;
          else              r_timer <= r_timer - L_ONE;
        end
        S_CAPTURE: begin
          // NOTE: DATA is deliberately unsynchronized; the hold phase guarantees it is stable here.
          r_wdata <= {r_to_flag, bus.DATA};
          r_ack   <= 1'b0;
          r_timer <= L_FULL_TO;
          r_state <= S_PUSH;
        end
        S_PUSH: begin
          if (!bus.fifo_full) begin
            r_we       <= 1'b1;
            r_word_cnt <= r_word_cnt + 16'd1;
            r_state    <= S_DONE;
          end else if (DROP_ON_FULL) begin
            if (w_timer_zero) begin
              r_drop_cnt <= (r_drop_cnt == 8'hFF) ? r_drop_cnt : r_drop_cnt + 8'd1;
              r_state    <= S_DONE;
            end else begin
              r_timer <= r_timer - L_ONE;
            end
          end
        end
        S_DONE: begin
          // A stuck-high LDAV must be seen low in IDLE before the next transfer may start.
          r_armed <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.LRFD            = ~r_ack;
  assign bus.fifo_write_en   = r_we;
  assign bus.fifo_write_data = r_wdata;
  assign busy                = (r_state != S_IDLE);
  assign word_cnt            = r_word_cnt;
  assign to_cnt              = r_to_cnt;
  assign drop_cnt            = r_drop_cnt;
  assign state               = r_state;

endmodule

// File: tb/tb_hp1349a_bus_rx.sv
// Randomized scoreboard bench: two receivers (keep-on-full and drop-on-full) share one
// stimulated bus; a transaction-level model predicts words and counters.
`timescale 1ns/1ps
module tb_hp1349a_bus_rx;
  localparam int DW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] tb_data;
  logic          tb_ldav;
  logic          tb_full;

  logic        busy_k, busy_d;
  logic [15:0] word_k, word_d;
  logic [7:0]  to_k, to_d, drop_k, drop_d;
  logic [2:0]  state_k, state_d;

  hp1349a_bus_rx_if #(.DATA_W(DW)) bus_k ();
  hp1349a_bus_rx_if #(.DATA_W(DW)) bus_d ();

  assign bus_k.DATA      = tb_data;
  assign bus_k.LDAV      = tb_ldav;
  assign bus_k.fifo_full = tb_full;
  assign bus_d.DATA      = tb_data;
  assign bus_d.LDAV      = tb_ldav;
  assign bus_d.fifo_full = tb_full;

  hp1349a_bus_rx #(
    .DATA_W(DW), .TMR_W(8), .SETTLE_CYC(4), .HOLD_CYC(4), .LDAV_TO(16),
    .DROP_ON_FULL(1'b0), .FULL_TO(8)
  ) dut_k (
    .clk(clk), .rst(rst), .en(en), .bus(bus_k), .busy(busy_k),
    .word_cnt(word_k), .to_cnt(to_k), .drop_cnt(drop_k), .state(state_k)
  );

  hp1349a_bus_rx #(
    .DATA_W(DW), .TMR_W(8), .SETTLE_CYC(4), .HOLD_CYC(4), .LDAV_TO(16),
    .DROP_ON_FULL(1'b1), .FULL_TO(8)
  ) dut_d (
    .clk(clk), .rst(rst), .en(en), .bus(bus_d), .busy(busy_d),
    .word_cnt(word_d), .to_cnt(to_d), .drop_cnt(drop_d), .state(state_d)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: expected FIFO words per receiver and expected counter values.
  logic [15:0] q_k[$];
  logic [15:0] q_d[$];
  int m_word_k = 0, m_word_d = 0, m_to = 0, m_drop_d = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the scoreboard whenever a receiver strobes a FIFO write.
  logic        prev_we_k = 1'b0, prev_we_d = 1'b0;
  logic [15:0] exp_wk, exp_wd;

  always @(negedge clk) begin
    if (rst) prev_we_k = 1'b0;
    else begin
      if (bus_k.fifo_write_en) begin
        check("k_write_expected", 32'(q_k.size() > 0), 1);
        check("k_single_pulse", 32'(prev_we_k), 0);
        check("k_lrfd_high_at_write", 32'(bus_k.LRFD), 1);
        if (q_k.size() > 0) begin
          exp_wk = q_k.pop_front();
          check("k_wdata", 32'(bus_k.fifo_write_data), 32'(exp_wk));
        end
      end
      prev_we_k = bus_k.fifo_write_en;
    end
  end

  always @(negedge clk) begin
    if (rst) prev_we_d = 1'b0;
    else begin
      if (bus_d.fifo_write_en) begin
        check("d_write_expected", 32'(q_d.size() > 0), 1);
        check("d_single_pulse", 32'(prev_we_d), 0);
        check("d_lrfd_high_at_write", 32'(bus_d.LRFD), 1);
        if (q_d.size() > 0) begin
          exp_wd = q_d.pop_front();
          check("d_wdata", 32'(bus_d.fifo_write_data), 32'(exp_wd));
        end
      end
      prev_we_d = bus_d.fifo_write_en;
    end
  end

  task automatic wait_lrfd(input logic val, input string name);
    int n;
    n = 0;
    while (bus_k.LRFD !== val && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus_k.LRFD), 32'(val));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_k || busy_d) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("return_to_idle", 32'({busy_k, busy_d}), 0);
  endtask

  task automatic check_model();
    check("word_cnt_k", 32'(word_k), 32'(m_word_k & 16'hFFFF));
    check("word_cnt_d", 32'(word_d), 32'(m_word_d & 16'hFFFF));
    check("to_cnt_k", 32'(to_k), 32'(m_to));
    check("to_cnt_d", 32'(to_d), 32'(m_to));
    check("drop_cnt_k", 32'(drop_k), 0);
    check("drop_cnt_d", 32'(drop_d), 32'(m_drop_d));
    check("queue_k_drained", 32'(q_k.size()), 0);
    check("queue_d_drained", 32'(q_d.size()), 0);
  endtask

  // One host transfer. tmo: hold LDAV until LRFD returns (forces release timeout).
  // full: FIFO reports full for the whole transfer plus 40 cycles.
  task automatic do_xfer(input bit tmo, input bit full, input int rel,
                         input bit en_off, input logic [DW-1:0] data, input bit rearm);
    logic [15:0] w;
    int bad;
    w = {tmo, data};
    tb_data = data;
    tb_full = full;
    en = 1'b1;
    q_k.push_back(w);
    m_word_k++;
    if (full) begin
      if (m_drop_d < 255) m_drop_d++;
    end else begin
      q_d.push_back(w);
      m_word_d++;
    end
    if (tmo && m_to < 255) m_to++;
    @(negedge clk);
    tb_ldav = 1'b1;
    wait_lrfd(1'b0, "lrfd_fall");
    if (en_off) en = 1'b0;
    if (!tmo) begin
      repeat (rel) @(negedge clk);
      tb_ldav = 1'b0;
    end
    wait_lrfd(1'b1, "lrfd_rise");
    if (tmo && rearm && !full) begin
      bad = 0;
      repeat (30) begin
        @(negedge clk);
        if (bus_k.LRFD !== 1'b1 || bus_d.LRFD !== 1'b1) bad++;
      end
      check("no_recapture_stuck_ldav", 32'(bad), 0);
      check("idle_with_stuck_ldav", 32'({busy_k, busy_d}), 0);
    end
    tb_ldav = 1'b0;
    if (full) begin
      repeat (40) @(negedge clk);
      check("d_idle_after_drop", 32'(busy_d), 0);
      check("k_still_waiting_full", 32'(state_k), 5);
      tb_full = 1'b0;
      @(negedge clk);
      check("k_write_after_full_falls", 32'(bus_k.fifo_write_en), 1);
    end
    wait_idle();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, bad;
    rst = 1'b1; en = 1'b0; tb_data = '0; tb_ldav = 1'b0; tb_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lrfd", 32'(bus_k.LRFD), 1);
    check("rst_state", 32'(state_k), 0);
    check("rst_we", 32'(bus_k.fifo_write_en), 0);
    check("rst_wdata", 32'(bus_k.fifo_write_data), 0);
    check("rst_word_cnt", 32'(word_k), 0);
    check("rst_to_cnt", 32'(to_k), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Directed: normal transfer, timeout with stuck LDAV, FIFO full on both variants.
    do_xfer(1'b0, 1'b0, 7, 1'b0, 15'h1234, 1'b0);
    do_xfer(1'b1, 1'b0, 0, 1'b0, 15'h5A5A, 1'b1);
    do_xfer(1'b0, 1'b1, 3, 1'b0, 15'h0F0F, 1'b0);

    // en low: LDAV pulses must not start a transfer.
    en = 1'b0;
    for (int p = 0; p < 4; p++) begin
      bad = 0;
      tb_ldav = 1'b1;
      repeat (8) begin
        @(negedge clk);
        if (bus_k.LRFD !== 1'b1 || busy_k || busy_d) bad++;
      end
      tb_ldav = 1'b0;
      repeat (4) @(negedge clk);
      check("en_low_stays_idle", 32'(bad), 0);
    end

    // Reset while in HOLD: word abandoned, LRFD released at once.
    en = 1'b1;
    tb_data = 15'h2222;
    @(negedge clk);
    tb_ldav = 1'b1;
    wait_lrfd(1'b0, "hold_lrfd_fall");
    tb_ldav = 1'b0;
    n = 0;
    while (state_k != 3'd3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_hold", 32'(state_k), 3);
    #2 rst = 1'b1;
    #1;
    check("rst_hold_lrfd_k", 32'(bus_k.LRFD), 1);
    check("rst_hold_lrfd_d", 32'(bus_d.LRFD), 1);
    check("rst_hold_state", 32'(state_k), 0);
    check("rst_hold_we", 32'(bus_k.fifo_write_en), 0);
    q_k.delete(); q_d.delete();
    m_word_k = 0; m_word_d = 0; m_to = 0; m_drop_d = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_model();

    // Randomized mix.
    for (int i = 0; i < 40; i++) begin
      do_xfer(1'($urandom % 2), 1'(($urandom % 4) == 0), int'($urandom_range(0, 8)),
              1'(($urandom % 3) == 0), DW'($urandom), 1'($urandom % 2));
    end

    // Timeout counter saturation.
    for (int i = 0; i < 300; i++) begin
      do_xfer(1'b1, 1'b0, 0, 1'(($urandom % 4) == 0), DW'($urandom), 1'b0);
    end
    check("to_cnt_saturated", 32'(to_k), 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hp1349a_bus_rx.md
HP1349A_BUS_RX -- requirements
Module: hp1349a_bus_rx

Interface
REQ-001 Parameter DATA_W, default 15, width of the HP1349A DATA bus.
REQ-002 Parameter TMR_W, default 8, width of the internal phase timer.
REQ-003 Parameter SETTLE_CYC, default 255, cycles held in SETTLE before LDAV release is checked.
REQ-004 Parameter HOLD_CYC, default 255, cycles held in HOLD before DATA is captured.
REQ-005 Parameter LDAV_TO, default 255, maximum cycles spent in WAIT_REL waiting for LDAV release.
REQ-006 Parameter DROP_ON_FULL, default 0, 1 = drop the word after FULL_TO cycles of fifo_full.
REQ-007 Parameter FULL_TO, default 255, cycles of fifo_full tolerated in PUSH when DROP_ON_FULL=1.
REQ-008 Parameters SETTLE_CYC, HOLD_CYC, LDAV_TO and FULL_TO SHALL each be in the range 1..2^TMR_W-1.
REQ-009 clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-010 rst  in  1  asynchronous, active-high reset.
REQ-011 en  in  1  receive enable, sampled only in IDLE.
REQ-012 DATA  in  DATA_W  HP1349A data bus.
REQ-013 LDAV  in  1  data-available strobe; 1 = data available.
REQ-014 LRFD  out  1  ready-for-data strobe; driven as the inverse of internal ack.
REQ-015 fifo_full  in  1  downstream FIFO full flag.
REQ-016 fifo_write_en  out  1  one-cycle FIFO write strobe.
REQ-017 fifo_write_data  out  DATA_W+1  {to_flag, captured DATA}.
REQ-018 busy  out  1  1 whenever state is not IDLE.
REQ-019 word_cnt  out  16  words written to the FIFO; wraps from 0xFFFF to 0.
REQ-020 to_cnt  out  8  LDAV-release timeouts; saturates at 0xFF.
REQ-021 drop_cnt  out  8  words dropped on FIFO full; saturates at 0xFF.
REQ-022 state  out  3  current FSM state encoding.

Function
REQ-023 LDAV SHALL pass through a 2-flop synchronizer (ldav_s); the FSM SHALL use only ldav_s.
REQ-024 DATA SHALL NOT be synchronized; it SHALL be sampled only in CAPTURE.
REQ-025 State encoding SHALL be IDLE=0, SETTLE=1, WAIT_REL=2, HOLD=3, CAPTURE=4, PUSH=5, DONE=6; code 7 SHALL return to IDLE.
REQ-026 IDLE: when en=1 and ldav_s=1, the FSM SHALL set ack=1, load timer=SETTLE_CYC and go to SETTLE.
REQ-027 SETTLE: timer SHALL decrement each cycle; at timer==0 the FSM SHALL load timer=LDAV_TO and go to WAIT_REL.
REQ-028 WAIT_REL: ldav_s=0 SHALL load timer=HOLD_CYC and go to HOLD with to_flag=0.
REQ-029 WAIT_REL: if ldav_s=1 and timer==0, the FSM SHALL go to HOLD with to_flag=1 and increment to_cnt (saturating); otherwise timer SHALL decrement.
REQ-030 HOLD: timer SHALL decrement to 0 and the FSM SHALL then go to CAPTURE.
REQ-031 CAPTURE: the FSM SHALL latch fifo_write_data={to_flag,DATA}, clear ack (LRFD returns high) and go to PUSH, all in one cycle.
REQ-032 PUSH: on entry timer SHALL be FULL_TO; if fifo_full=0 the FSM SHALL pulse fifo_write_en for exactly one cycle, increment word_cnt and go to DONE.
REQ-033 PUSH with fifo_full=1 and DROP_ON_FULL=0 SHALL wait indefinitely.
REQ-034 PUSH with fifo_full=1 and DROP_ON_FULL=1 SHALL decrement timer; at timer==0 the FSM SHALL drop the word, increment drop_cnt (saturating), skip the write and go to DONE.
REQ-035 DONE SHALL hold for one cycle with fifo_write_en=0 and then return to IDLE.
REQ-036 A new transfer SHALL NOT start until ldav_s has been observed 0 in IDLE after DONE, so that a stuck LDAV cannot cause repeated capture.
REQ-037 fifo_write_data SHALL hold its value outside CAPTURE.
REQ-038 en=0 SHALL NOT abort a transfer already in progress.

Reset
REQ-039 On rst=1, asynchronously: state=IDLE, ack=0 (LRFD=1), fifo_write_en=0, fifo_write_data=0, timer=0, to_flag=0, all counters=0, synchronizer flops=0, rearm latch cleared.
REQ-040 rst asserted mid-transfer SHALL abandon the word with no FIFO write and release LRFD immediately.

Verification (SETTLE_CYC=4, HOLD_CYC=4, LDAV_TO=16, FULL_TO=8)
REQ-041 Normal: en=1, DATA=0x1234, LDAV high 10 cycles then low, fifo_full=0 -> one write of 0x01234, word_cnt=1, LRFD low then high before the write strobe.
REQ-042 Timeout: LDAV held high -> to_cnt=1, write of {1,DATA}, and no second capture until LDAV falls and rises again.
REQ-043 Full, DROP_ON_FULL=0: fifo_full=1 for 50 cycles then 0 -> write occurs one cycle after fifo_full falls, drop_cnt=0.
REQ-044 Full, DROP_ON_FULL=1: fifo_full held 1 -> no write, drop_cnt=1, FSM returns to IDLE.
REQ-045 Reset in HOLD -> LRFD=1 and state=0 immediately, no fifo_write_en pulse, counters=0.
REQ-046 en=0 with LDAV pulsing -> FSM stays in IDLE with LRFD=1; saturation check: 300 timeouts -> to_cnt=0xFF.
